// File: rtl/mips_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_cpu_bus_arbiter
//
// Shares one Avalon-MM master port between the instruction-fetch requester and
// the data requester of a MIPS core. Only one transaction is outstanding at a
// time. Arbitration is round-robin on the last grantee, so the fetch side wins
// the first tie after reset.
//
// Ports
//   clk, reset               clock; asynchronous reset, active low
//   f_req, f_addr            fetch read request (held until f_ack)
//   f_ack, f_rdata           fetch completion pulse and registered read word
//   d_req, d_we, d_addr,
//   d_wdata, d_be            data request (held, with stable operands, until d_ack)
//   d_ack, d_rdata           data completion pulse and registered read word
//   address, read, write,
//   writedata, byteenable    Avalon master command
//   waitrequest, readdata    Avalon slave stall and read data
//   busy                     high whenever the arbiter is not idle
//
// Transaction flow: IDLE -> ISSUE (held while waitrequest) -> [RDWAIT for
// reads] -> RESP (ack pulse) -> IDLE. Read data is sampled in RDWAIT, one
// cycle after the slave accepts the read.
// -----------------------------------------------------------------------------
module mips_cpu_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    // fetch requester
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic [31:0] f_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    // Avalon-MM master
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    // status
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    state_t      state_q,      state_d;
    grant_t      last_grant_q, last_grant_d;
    grant_t      grant_q,      grant_d;
    grant_t      pick;
    logic        we_q,         we_d;
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic [3:0]  be_q,         be_d;
    logic [31:0] f_rdata_q,    f_rdata_d;
    logic [31:0] d_rdata_q,    d_rdata_d;

    // Round-robin pick: on a tie the side not granted last time wins; a lone
    // requester always wins.
    always_comb begin
        pick = GRANT_FETCH;
        if (f_req && d_req) begin
            pick = (last_grant_q == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
        end else if (d_req) begin
            pick = GRANT_DATA;
        end
    end

    // NOTE: every signal this block drives gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    state_d      = ISSUE;
                    if (pick == GRANT_FETCH) begin
                        // Fetches are always full-word reads.
                        we_d    = 1'b0;
                        addr_d  = f_addr & 32'hFFFF_FFFC;
                        wdata_d = 32'h0;
                        be_d    = 4'hF;
                    end else begin
                        // A write with d_be == 0 is still issued as given.
                        we_d    = d_we;
                        addr_d  = d_addr & 32'hFFFF_FFFC;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                    end
                end
            end
            ISSUE: begin
                if (!waitrequest) begin
                    state_d = we_q ? RESP : RDWAIT;
                end
            end
            RDWAIT: begin
                // readdata is valid exactly one cycle after acceptance; only
                // the grantee's register is updated.
                if (grant_q == GRANT_FETCH) begin
                    f_rdata_d = readdata;
                end else begin
                    d_rdata_d = readdata;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    // NOTE: all registers here are plain flops (no memory arrays), so every
    // one is cleared by the asynchronous reset; last_grant resets to DATA so
    // the first tie goes to fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DATA;
            grant_q      <= GRANT_FETCH;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            f_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Outputs are decoded from registered state only, so reset clears the
    // bus strobes and acks immediately, without waiting for a clock edge.
    assign read       = (state_q == ISSUE) && !we_q;
    assign write      = (state_q == ISSUE) &&  we_q;
    assign address    = addr_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;
    assign f_ack      = (state_q == RESP) && (grant_q == GRANT_FETCH);
    assign d_ack      = (state_q == RESP) && (grant_q == GRANT_DATA);
    assign f_rdata    = f_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_bus_arbiter
//
// Directed scenarios plus a randomized run. The reference model works at the
// transaction level: which requester is served next (round-robin on the last
// grantee), the word-aligned command it should see, how many cycles until its
// ack, and what each rdata register must hold afterwards.
//
// Cycle counting: inputs are applied before edge E0 that samples them; the
// ack is seen in cycle k after E0 where k = 3 + stalls for reads and
// k = 2 + stalls for writes (the 4 and 3 cycles of the latency rule when the
// sampling cycle itself is counted).
// -----------------------------------------------------------------------------
module tb_mips_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_we, waitrequest;
    logic [31:0] f_addr, d_addr, d_wdata, readdata;
    logic [3:0]  d_be;
    logic        f_ack, d_ack, read, write, busy;
    logic [31:0] f_rdata, d_rdata, address, writedata;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_ack      (f_ack),
        .f_rdata    (f_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .waitrequest(waitrequest),
        .readdata   (readdata),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_last_data;
    logic [31:0] m_f_rdata, m_d_rdata;

    // observations from one transaction
    int          o_lat, o_issue_cycles;
    bit          o_timeout, o_stable, o_post_ack, o_post_busy;
    logic [1:0]  o_acks;          // {f_ack, d_ack} in the ack cycle
    logic [69:0] o_cmd;           // {read, write, address, writedata, byteenable}
    logic [31:0] o_f_rdata, o_d_rdata;

    function automatic void model_reset();
        m_last_data = 1'b1;
        m_f_rdata   = 32'h0;
        m_d_rdata   = 32'h0;
    endfunction

    // 1 = data served next, 0 = fetch served next
    function automatic bit model_pick(input bit f, input bit d);
        if (f && d) return !m_last_data;
        return d;
    endfunction

    function automatic logic [69:0] model_cmd(input bit is_data);
        if (!is_data) return {1'b1, 1'b0, f_addr & 32'hFFFF_FFFC, 32'h0, 4'hF};
        return {~d_we, d_we, d_addr & 32'hFFFF_FFFC, d_wdata, d_be};
    endfunction

    // Runs the bus slave for one transaction, starting just before the edge
    // that samples the requests. Ends at the negedge of the cycle after the
    // ack. The acked requester is released in its ack cycle; if drop_at > 0
    // both requests are withdrawn early in cycle drop_at.
    task automatic do_txn(input int stalls, input logic [31:0] rd_value, input int drop_at);
        int left;
        bit seen, accepted_prev, done;
        logic [69:0] cur;
        left = stalls; seen = 0; accepted_prev = 0; done = 0;
        o_lat = 0; o_issue_cycles = 0; o_timeout = 0; o_stable = 1;
        o_acks = 2'b00; o_cmd = '0; o_post_ack = 0; o_post_busy = 0;
        waitrequest = 1'b0;
        while (!done && o_lat < 60) begin
            @(posedge clk);
            o_lat++;
            @(negedge clk);
            readdata = accepted_prev ? rd_value : $urandom;
            accepted_prev = 0;
            if (drop_at > 0 && o_lat == drop_at) begin
                f_req = 1'b0;
                d_req = 1'b0;
            end
            if (read || write) begin
                cur = {read, write, address, writedata, byteenable};
                o_issue_cycles++;
                if (!seen) begin
                    seen = 1;
                    o_cmd = cur;
                end else if (cur !== o_cmd) begin
                    o_stable = 0;
                end
                if (left > 0) begin
                    waitrequest = 1'b1;
                    left--;
                end else begin
                    waitrequest = 1'b0;
                    accepted_prev = read;
                end
            end else begin
                waitrequest = 1'b0;
            end
            if (f_ack || d_ack) begin
                o_acks    = {f_ack, d_ack};
                o_f_rdata = f_rdata;
                o_d_rdata = d_rdata;
                if (f_ack) f_req = 1'b0;
                if (d_ack) d_req = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            o_timeout = 1;
        end else begin
            @(posedge clk);
            @(negedge clk);
            o_post_ack  = f_ack || d_ack;
            o_post_busy = busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        f_req = 0; d_req = 0; d_we = 0; waitrequest = 0;
        f_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; readdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({read, write, address, writedata, byteenable, f_ack, d_ack, f_rdata, d_rdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wd=%h be=%h fa=%b da=%b frd=%h drd=%h busy=%b, want all zero",
                     read, write, address, writedata, byteenable, f_ack, d_ack, f_rdata, d_rdata, busy);
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_fetch();
        f_req = 1; f_addr = 32'hBFC0_0003;
        do_txn(0, 32'h2402_0005, 0);
        checks++;
        if (o_timeout || o_acks !== 2'b10) begin
            errors++; $display("FAIL fetch_ack: got acks=%b timeout=%0d, want 10", o_acks, o_timeout);
        end
        checks++;
        if (o_lat !== 3) begin
            errors++; $display("FAIL fetch_latency: got %0d want 3", o_lat);
        end
        checks++;
        if (o_cmd !== {1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF} || o_issue_cycles !== 1) begin
            errors++; $display("FAIL fetch_cmd: got %h (%0d cycles) want %h (1 cycle)",
                               o_cmd, o_issue_cycles, {1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF});
        end
        checks++;
        if (o_f_rdata !== 32'h2402_0005) begin
            errors++; $display("FAIL fetch_rdata: got %h want 24020005", o_f_rdata);
        end
        checks++;
        if (o_post_ack || o_post_busy) begin
            errors++; $display("FAIL fetch_after_ack: got ack=%b busy=%b want 0 0", o_post_ack, o_post_busy);
        end
        m_last_data = 0; m_f_rdata = 32'h2402_0005;
    endtask

    task automatic test_write_stall();
        d_req = 1; d_we = 1; d_addr = 32'h0000_1008; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        do_txn(3, 32'h1111_2222, 0);
        checks++;
        if (o_timeout || o_acks !== 2'b01) begin
            errors++; $display("FAIL wr_ack: got acks=%b timeout=%0d, want 01", o_acks, o_timeout);
        end
        checks++;
        if (o_lat !== 5) begin
            errors++; $display("FAIL wr_latency: got %0d want 5", o_lat);
        end
        checks++;
        if (o_cmd !== {1'b0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0011} || !o_stable || o_issue_cycles !== 4) begin
            errors++; $display("FAIL wr_cmd_stable: got %h stable=%0d cycles=%0d want %h stable=1 cycles=4",
                               o_cmd, o_stable, o_issue_cycles, {1'b0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0011});
        end
        checks++;
        if (o_d_rdata !== m_d_rdata || o_f_rdata !== m_f_rdata) begin
            errors++; $display("FAIL wr_rdata_hold: got f=%h d=%h want f=%h d=%h", o_f_rdata, o_d_rdata, m_f_rdata, m_d_rdata);
        end
        m_last_data = 1;
    endtask

    task automatic test_data_read();
        d_req = 1; d_we = 0; d_addr = 32'h0000_0010; d_wdata = 32'h0; d_be = 4'hF;
        do_txn(1, 32'hCAFE_F00D, 0);
        checks++;
        if (o_timeout || o_acks !== 2'b01 || o_lat !== 4) begin
            errors++; $display("FAIL rd_ack: got acks=%b lat=%0d want 01 lat=4", o_acks, o_lat);
        end
        checks++;
        if (o_d_rdata !== 32'hCAFE_F00D || o_f_rdata !== m_f_rdata) begin
            errors++; $display("FAIL rd_rdata: got d=%h f=%h want d=cafef00d f=%h", o_d_rdata, o_f_rdata, m_f_rdata);
        end
        m_last_data = 1; m_d_rdata = 32'hCAFE_F00D;
    endtask

    // Tie after reset goes to fetch; the held d_req is served next; fetch
    // re-raising alongside it forms a second tie, which goes to data first.
    task automatic test_tie();
        bit exp_data [3] = '{1'b0, 1'b1, 1'b0};
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        f_req = 1; d_req = 1; f_addr = 32'h0000_0104; d_we = 1; d_addr = 32'h0000_2000;
        d_wdata = 32'h1234_5678; d_be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) f_req = 1;   // fetch comes back while data still waits
            do_txn(0, 32'hA5A5_0000 + i, 0);
            checks++;
            if (o_timeout || o_acks !== (exp_data[i] ? 2'b01 : 2'b10) || o_post_busy) begin
                errors++; $display("FAIL tie_order_%0d: got acks=%b idle_gap_busy=%b want %b 0",
                                   i, o_acks, o_post_busy, exp_data[i] ? 2'b01 : 2'b10);
            end
        end
        m_last_data = 0; m_f_rdata = 32'hA5A5_0002;
    endtask

    // Write with no byte enables is still issued; a fetch withdrawn early
    // still completes.
    task automatic test_corner();
        d_req = 1; d_we = 1; d_addr = 32'h0000_3003; d_wdata = 32'h5555_AAAA; d_be = 4'b0000;
        do_txn(0, 32'h0, 0);
        checks++;
        if (o_acks !== 2'b01 || o_cmd !== {1'b0, 1'b1, 32'h0000_3000, 32'h5555_AAAA, 4'b0000}) begin
            errors++; $display("FAIL be_zero_write: got acks=%b cmd=%h want 01 %h",
                               o_acks, o_cmd, {1'b0, 1'b1, 32'h0000_3000, 32'h5555_AAAA, 4'b0000});
        end
        m_last_data = 1;
        f_req = 1; f_addr = 32'h0000_0040;
        do_txn(0, 32'h0BAD_F00D, 1);
        checks++;
        if (o_acks !== 2'b10 || o_lat !== 3 || o_f_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL dropped_req: got acks=%b lat=%0d rdata=%h want 10 3 0badf00d", o_acks, o_lat, o_f_rdata);
        end
        m_last_data = 0; m_f_rdata = 32'h0BAD_F00D;
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 1; d_addr = 32'h0000_4000; d_wdata = 32'hFFFF_0000; d_be = 4'hF;
        waitrequest = 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (write !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_issue: got write=%b busy=%b want 1 1", write, busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({read, write, f_ack, d_ack, busy} !== 5'b0) begin
            errors++; $display("FAIL async_abort: got rd=%b wr=%b fa=%b da=%b busy=%b want all 0",
                               read, write, f_ack, d_ack, busy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({f_ack, d_ack, f_rdata, d_rdata} !== '0) begin
            errors++; $display("FAIL abort_no_ack: got fa=%b da=%b frd=%h drd=%h want 0", f_ack, d_ack, f_rdata, d_rdata);
        end
        d_req = 0; waitrequest = 0;
        reset = 1'b1;
        model_reset();
        f_req = 1; f_addr = 32'h0000_0080;
        do_txn(0, 32'h7777_8888, 0);
        checks++;
        if (o_acks !== 2'b10 || o_lat !== 3 || o_f_rdata !== 32'h7777_8888 || o_d_rdata !== 32'h0) begin
            errors++; $display("FAIL after_reset_txn: got acks=%b lat=%0d f=%h d=%h want 10 3 77778888 0",
                               o_acks, o_lat, o_f_rdata, o_d_rdata);
        end
        m_last_data = 0; m_f_rdata = 32'h7777_8888;
    endtask

    task automatic test_random();
        bit          pend_f, pend_d, is_data;
        int          stalls, exp_lat;
        logic [31:0] rd_value;
        logic [69:0] exp;
        for (int n = 0; n < 40; n++) begin
            int mask = $urandom_range(3, 1);
            pend_f = mask[0]; pend_d = mask[1];
            f_req = pend_f; d_req = pend_d;
            f_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_we = $urandom_range(1, 0); d_be = 4'($urandom);
            while (pend_f || pend_d) begin
                is_data  = model_pick(pend_f, pend_d);
                stalls   = $urandom_range(3, 0);
                rd_value = $urandom;
                exp      = model_cmd(is_data);
                exp_lat  = ((is_data && d_we) ? 2 : 3) + stalls;
                do_txn(stalls, rd_value, 0);
                if (exp[69]) begin
                    if (is_data) m_d_rdata = rd_value;
                    else         m_f_rdata = rd_value;
                end
                checks++;
                if (o_timeout || o_acks !== (is_data ? 2'b01 : 2'b10) || o_lat !== exp_lat) begin
                    errors++; $display("FAIL rand_%0d_grant: got acks=%b lat=%0d want %b lat=%0d",
                                       n, o_acks, o_lat, is_data ? 2'b01 : 2'b10, exp_lat);
                end
                checks++;
                if (o_cmd !== exp || !o_stable || o_issue_cycles !== stalls + 1) begin
                    errors++; $display("FAIL rand_%0d_cmd: got %h stable=%0d cycles=%0d want %h cycles=%0d",
                                       n, o_cmd, o_stable, o_issue_cycles, exp, stalls + 1);
                end
                checks++;
                if (o_f_rdata !== m_f_rdata || o_d_rdata !== m_d_rdata || o_post_ack || o_post_busy) begin
                    errors++; $display("FAIL rand_%0d_rdata: got f=%h d=%h post_ack=%b post_busy=%b want f=%h d=%h 0 0",
                                       n, o_f_rdata, o_d_rdata, o_post_ack, o_post_busy, m_f_rdata, m_d_rdata);
                end
                m_last_data = is_data;
                if (is_data) pend_d = 0;
                else         pend_f = 0;
                if (o_timeout) begin
                    pend_f = 0; pend_d = 0; f_req = 0; d_req = 0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_stall();
        test_data_read();
        test_tie();
        test_corner();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
MIPS_CPU_BUS_ARBITER -- requirements
Module: mips_cpu_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset; all other signals SHALL be synchronous to the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  asynchronous reset, asserted when 0.
REQ-004 f_req  input  1  fetch requester read request; held high until f_ack.
REQ-005 f_addr  input  32  fetch byte address.
REQ-006 f_ack  output  1  one-cycle pulse; f_rdata is valid in the same cycle.
REQ-007 f_rdata  output  32  registered fetched word.
REQ-008 d_req  input  1  data requester request; held high, with stable operands, until d_ack.
REQ-009 d_we  input  1  1 selects write, 0 selects read.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  write data.
REQ-012 d_be  input  4  byte enables.
REQ-013 d_ack  output  1  one-cycle completion pulse.
REQ-014 d_rdata  output  32  registered read word, valid while d_ack is high.
REQ-015 address, read, write, writedata, byteenable  output  32/1/1/32/4  Avalon master command.
REQ-016 waitrequest  input  1  slave stall; readdata  input  32  read data, valid one cycle after a read is accepted.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, RDWAIT and RESP.
REQ-019 In IDLE, if any request is high at a clock edge, the block SHALL pick a grantee, latch its address, data, byte enables and operation, and go to ISSUE.
REQ-020 Arbitration SHALL be round-robin on a last_grant register: on a tie, the requester not granted last wins; a single requester always wins.
REQ-021 Latched address bits [1:0] SHALL be forced to 0, giving word-aligned output.
REQ-022 A fetch SHALL always be a read with byteenable 4'b1111 and writedata 0.
REQ-023 In ISSUE, read = ~latched_we, write = latched_we, and address/writedata/byteenable SHALL be driven from the latches; all of these SHALL be held stable while waitrequest=1.
REQ-024 ISSUE SHALL exit only at an edge with waitrequest=0: a write goes to RESP, a read goes to RDWAIT.
REQ-025 In RDWAIT, the block SHALL capture readdata into the grantee's rdata register at the next edge and go to RESP; there SHALL be no waitrequest dependence in RDWAIT.
REQ-026 In RESP, the block SHALL assert exactly the grantee's ack for one cycle, then go to IDLE.
REQ-027 read and write SHALL be 0 in IDLE, RDWAIT and RESP.
REQ-028 The non-granted rdata register SHALL hold its value.
REQ-029 Minimum latency, measured from the edge sampling req to the ack cycle, SHALL be 3 cycles for a write and 4 cycles for a read, plus one cycle per waitrequest stall.
REQ-030 A request arriving in a non-IDLE state SHALL wait; there SHALL be no preemption.
REQ-031 The cycle after RESP is IDLE, so back-to-back transactions are separated by at least one IDLE cycle.
REQ-032 A request deasserted before ack is a requester protocol violation; the latched transaction SHALL still complete.
REQ-033 d_we=1 with d_be=4'b0000 SHALL still issue the bus write as given.

Reset
REQ-034 While reset=0, regardless of clk: state=IDLE, read=0, write=0, address=0, writedata=0, byteenable=0, f_ack=0, d_ack=0, f_rdata=0, d_rdata=0, busy=0, and last_grant=data, so fetch wins the first tie.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately with no ack; after release, operation SHALL restart in IDLE.

Verification
REQ-036 Fetch only: f_req=1, f_addr=32'hBFC00003, waitrequest=0, readdata=32'h24020005 in the RDWAIT cycle -> read=1 with address=32'hBFC00000 and byteenable=4'hF for one cycle; f_ack pulses 4 cycles after the request edge with f_rdata=32'h24020005.
REQ-037 Data write with stalls: d_req=1, d_we=1, d_addr=32'h00001008, d_wdata=32'hDEADBEEF, d_be=4'b0011, waitrequest=1 for 3 cycles -> write and all command outputs stable for 4 cycles; d_ack follows 1 cycle after acceptance; read stays 0 throughout.
REQ-038 Tie after reset: f_req and d_req rise together -> fetch is served first; d_req, held high, is served next after one IDLE cycle; a second simultaneous pair is served data first, then fetch.
REQ-039 Data read: d_req=1, d_we=0, d_addr=32'h00000010, readdata=32'hCAFEF00D -> d_rdata=32'hCAFEF00D while d_ack=1; f_rdata is unchanged.
REQ-040 Reset mid-ISSUE: reset=0 asynchronously during waitrequest=1 -> read and write drop to 0 before the next clk edge, no ack is produced, busy=0; a new request after release completes normally.
